// File: rtl/muldiv_unit_if.sv
// Control/data bundle between the E-stage and the multiply/divide unit.
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic        madd;
    logic        wr;
    logic        wr_hi;
    logic        rd_lo;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hilo_rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, madd, wr, wr_hi, rd_lo, a, b,
        input  busy, hilo_rdata, hi, lo
    );

    modport slave (
        input  start, op, madd, wr, wr_hi, rd_lo, a, b,
        output busy, hilo_rdata, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO, computes the result at
// acceptance and holds it back for a fixed multi-cycle latency.
module muldiv_unit #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);

    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    // Destination mode captured with the result
    localparam logic [1:0] MODE_LOAD = 2'd0;  // {HI,LO} <= result
    localparam logic [1:0] MODE_ACC  = 2'd1;  // {HI,LO} <= {HI,LO} + result
    localparam logic [1:0] MODE_KEEP = 2'd2;  // divide by zero: no update

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [63:0]   res;
    logic [1:0]    mode;
    logic [31:0]   hi_r;
    logic [31:0]   lo_r;

    logic [63:0]   res_next;
    logic [1:0]    mode_next;
    logic [63:0]   mul_a;
    logic [63:0]   mul_b;
    logic          div_signed;
    logic          a_neg;
    logic          b_neg;
    logic [31:0]   div_a;
    logic [31:0]   div_b;
    logic [31:0]   quo;
    logic [31:0]   rem;

    // Result and destination mode for the operation presented this cycle
    always_comb begin
        res_next   = '0;
        mode_next  = MODE_LOAD;
        div_signed = bus.op[0];
        a_neg      = div_signed & bus.a[31];
        b_neg      = div_signed & bus.b[31];
        div_a      = a_neg ? (~bus.a + 32'd1) : bus.a;
        div_b      = b_neg ? (~bus.b + 32'd1) : bus.b;
        quo        = '0;
        rem        = '0;
        // One 64-bit multiplier: sign- or zero-extend operands, keep low 64 bits
        mul_a      = {{32{bus.op[0] & bus.a[31]}}, bus.a};
        mul_b      = {{32{bus.op[0] & bus.b[31]}}, bus.b};

        if (!bus.op[1]) begin
            res_next = mul_a * mul_b;
            if (bus.op[0] && bus.madd) begin
                mode_next = MODE_ACC;
            end
        end else if (div_b == '0) begin
            mode_next = MODE_KEEP;
        end else begin
            // Divide magnitudes, then restore signs: quotient truncates toward
            // zero, remainder follows the dividend. 0x80000000/-1 falls out as
            // 0x80000000 remainder 0 without a special case.
            quo = div_a / div_b;
            rem = div_a % div_b;
            if (a_neg ^ b_neg) begin
                quo = ~quo + 32'd1;
            end
            if (a_neg) begin
                rem = ~rem + 32'd1;
            end
            res_next = {rem, quo};
        end
    end

    // Control FSM, latency counter and HI/LO register pair
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            res   <= '0;
            mode  <= MODE_LOAD;
            hi_r  <= '0;
            lo_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        res   <= res_next;
                        mode  <= mode_next;
                        cnt   <= bus.op[1] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                        state <= RUN;
                    end else if (bus.wr) begin
                        if (bus.wr_hi) begin
                            hi_r <= bus.a;
                        end else begin
                            lo_r <= bus.a;
                        end
                    end
                end
                RUN: begin
                    if (cnt == CW'(1)) begin
                        case (mode)
                            MODE_LOAD: {hi_r, lo_r} <= res;
                            MODE_ACC:  {hi_r, lo_r} <= {hi_r, lo_r} + res;
                            default:   ;
                        endcase
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Committed-state outputs; in-flight results are never forwarded
    always_comb begin
        bus.busy       = (state == RUN);
        bus.hi         = hi_r;
        bus.lo         = lo_r;
        bus.hilo_rdata = bus.rd_lo ? lo_r : hi_r;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against an arithmetic model.
module tb_muldiv_unit;

    localparam int unsigned MUL_N = 5;
    localparam int unsigned DIV_N = 10;

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    logic [31:0] hi_m;
    logic [31:0] lo_m;

    muldiv_unit_if bus ();

    muldiv_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: ISA-level meaning of each operation
    task automatic model_op(input logic [1:0] op, input logic madd,
                            input logic [31:0] a, input logic [31:0] b);
        longint unsigned ua, ub;
        longint          sa, sb, q, r;
        logic [63:0]     p, acc, qv, rv;
        ua = a;
        ub = b;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'b00: begin
                p = ua * ub;
                {hi_m, lo_m} = p;
            end
            2'b01: begin
                p = sa * sb;
                acc = {hi_m, lo_m};
                if (madd) {hi_m, lo_m} = acc + p;
                else      {hi_m, lo_m} = p;
            end
            2'b10: begin
                if (b != 0) begin
                    lo_m = a / b;
                    hi_m = a % b;
                end
            end
            default: begin
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    qv = q;
                    rv = r;
                    lo_m = qv[31:0];
                    hi_m = rv[31:0];
                end
            end
        endcase
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_hi"}, bus.hi, hi_m);
        check({tag, "_lo"}, bus.lo, lo_m);
        bus.rd_lo = 1'b1;
        #1 check({tag, "_rd_lo"}, bus.hilo_rdata, lo_m);
        bus.rd_lo = 1'b0;
        #1 check({tag, "_rd_hi"}, bus.hilo_rdata, hi_m);
    endtask

    // mthi/mtlo
    task automatic move_to(input logic sel_hi, input logic [31:0] v);
        @(negedge clk);
        bus.wr    = 1'b1;
        bus.wr_hi = sel_hi;
        bus.a     = v;
        @(negedge clk);
        bus.wr = 1'b0;
        if (sel_hi) hi_m = v;
        else        lo_m = v;
        check_regs("mt");
    endtask

    // Launch one op; optionally also assert wr with it, or re-assert start while busy
    task automatic run_op(input string tag, input logic [1:0] op, input logic madd,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic restart, input logic with_wr);
        int unsigned exp_n;
        int unsigned cycles;
        logic [31:0] old_hi, old_lo;
        exp_n  = op[1] ? DIV_N : MUL_N;
        old_hi = hi_m;
        old_lo = lo_m;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.madd  = madd;
        bus.a     = a;
        bus.b     = b;
        bus.wr    = with_wr;
        bus.wr_hi = 1'b1;
        cycles    = 0;
        while (cycles < 40) begin
            @(negedge clk);
            if (!bus.busy) break;
            cycles++;
            if (cycles == 1) begin
                bus.start = 1'b0;
                bus.wr    = 1'b0;
                bus.rd_lo = 1'b1;
                #1 check({tag, "_old_lo"}, bus.hilo_rdata, old_lo);
                bus.rd_lo = 1'b0;
                #1 check({tag, "_old_hi"}, bus.hilo_rdata, old_hi);
            end
            if (restart && cycles == 2) begin
                bus.start = 1'b1;
                bus.op    = 2'b00;
                bus.madd  = 1'b0;
                bus.a     = 32'h1234_5678;
                bus.b     = 32'h0000_0100;
            end
            if (cycles == 3) bus.start = 1'b0;
        end
        bus.start = 1'b0;
        bus.wr    = 1'b0;
        check({tag, "_busy_cycles"}, 64'(cycles), 64'(exp_n));
        model_op(op, madd, a, b);
        check_regs(tag);
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        hi_m      = '0;
        lo_m      = '0;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.madd  = 1'b0;
        bus.wr    = 1'b0;
        bus.wr_hi = 1'b0;
        bus.rd_lo = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", bus.busy, 1'b0);
        check_regs("reset");
        reset = 1'b1;

        run_op("mult", 2'b01, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        check("mult_hi_const", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo_const", bus.lo, 32'hFFFF_FFFE);
        run_op("multu", 2'b00, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        check("multu_hi_const", bus.hi, 32'h0000_0001);
        run_op("div", 2'b11, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check("div_lo_const", bus.lo, 32'hFFFF_FFFD);
        check("div_hi_const", bus.hi, 32'hFFFF_FFFF);
        run_op("divu", 2'b10, 1'b0, 32'd7, 32'd2, 1'b0, 1'b0);
        check("divu_lo_const", bus.lo, 32'd3);
        move_to(1'b0, 32'd5);
        move_to(1'b1, 32'd0);
        run_op("madd", 2'b01, 1'b1, 32'd3, 32'd4, 1'b1, 1'b0);
        check("madd_lo_const", bus.lo, 32'h11);
        move_to(1'b1, 32'hAA);
        move_to(1'b0, 32'hBB);
        run_op("div0", 2'b11, 1'b0, 32'd99, 32'd0, 1'b0, 1'b0);
        check("div0_hi_const", bus.hi, 32'hAA);
        run_op("divovf", 2'b11, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("divovf_lo_const", bus.lo, 32'h8000_0000);
        // start and wr together: write is dropped (model ignores it)
        run_op("start_wr", 2'b00, 1'b0, 32'h0000_0003, 32'h0000_0007, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  r_op;
            logic [31:0] r_a, r_b;
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            case ($urandom_range(0, 5))
                0:       r_b = 32'd0;
                1:       r_b = 32'($urandom_range(1, 9));
                2:       r_b = 32'hFFFF_FFFF;
                default: r_b = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) move_to(1'($urandom_range(0, 1)), $urandom);
            run_op("rand", r_op, 1'($urandom_range(0, 1)), r_a, r_b,
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
        end

        // Reset mid-divide: asynchronous clear, no later commit
        move_to(1'b1, 32'h1234);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        hi_m = '0;
        lo_m = '0;
        #1 check("arst_busy", bus.busy, 1'b0);
        check("arst_hi", bus.hi, 32'd0);
        check("arst_lo", bus.lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check("post_rst_busy", bus.busy, 1'b0);
        end
        check_regs("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
